fabosc_rst_seq: RTL and testbench



---
 rtl/fabosc_rst_pkg.sv | 20 ++
 rtl/fabosc_sync_bit.sv | 32 +++
 rtl/fabosc_rst_seq.sv | 156 +++++++++++++++
 tb/tb_fabosc_rst_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fabosc_rst_pkg.sv
// Shared types and constants for the fabric-oscillator reset sequencer.
package fabosc_rst_pkg;

    typedef enum logic [2:0] {
        RST_HOLD  = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        CORE_UP   = 3'd3,
        RUN       = 3'd4,
        SW_HOLD   = 3'd5
    } state_t;

    localparam int LOSS_CNT_W = 8;

    // Width of a counter that runs 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fabosc_sync_bit.sv
// Multi-stage flip-flop synchroniser with asynchronous active-high clear.
module fabosc_sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) sync_reg[gi] <= 1'b0;
                    else     sync_reg[gi] <= d;
                end
            end else begin : g_rest
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) sync_reg[gi] <= 1'b0;
                    else     sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign q = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/fabosc_rst_seq.sv
// Reset sequencer: qualifies PLL lock, releases core reset, then peripheral
// reset after a stagger; handles filtered lock loss, button and software reset.
module fabosc_rst_seq
    import fabosc_rst_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGGER_CYCLES     = 16,
    parameter int LOSS_FILTER        = 4,
    parameter int SW_HOLD_CYCLES     = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  PLL_LOCK,
    input  logic                  EXT_RST_N,
    input  logic                  SW_RST_REQ,
    output logic                  FAB_RESET_N,
    output logic                  PERIPH_RESET_N,
    output logic                  READY,
    output logic [2:0]            STATE,
    output logic [LOSS_CNT_W-1:0] LOCK_LOSS_CNT
);

    localparam int STABLE_W = cnt_width(LOCK_STABLE_CYCLES);
    localparam int STAG_W   = cnt_width(STAGGER_CYCLES);
    localparam int LOSS_W   = cnt_width(LOSS_FILTER);
    localparam int HOLD_W   = cnt_width(SW_HOLD_CYCLES);

    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [STAG_W-1:0]   STAG_LAST   = STAG_W'(STAGGER_CYCLES - 1);
    localparam logic [LOSS_W-1:0]   LOSS_LAST   = LOSS_W'(LOSS_FILTER - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(SW_HOLD_CYCLES - 1);

    logic lock_s;
    logic extn_s;

    fabosc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lock (
        .clk (CLK),
        .rst (RESET),
        .d   (PLL_LOCK),
        .q   (lock_s)
    );

    fabosc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_extn (
        .clk (CLK),
        .rst (RESET),
        .d   (EXT_RST_N),
        .q   (extn_s)
    );

    state_t                  state_reg;
    logic [STABLE_W-1:0]     stable_cnt_reg;
    logic [STAG_W-1:0]       stag_cnt_reg;
    logic [LOSS_W-1:0]       loss_cnt_reg;
    logic [HOLD_W-1:0]       hold_cnt_reg;
    logic [LOSS_CNT_W-1:0]   loss_total_reg;
    logic                    fab_n_reg;
    logic                    periph_n_reg;
    logic                    ready_reg;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg      <= RST_HOLD;
            stable_cnt_reg <= '0;
            stag_cnt_reg   <= '0;
            loss_cnt_reg   <= '0;
            hold_cnt_reg   <= '0;
            loss_total_reg <= '0;
            fab_n_reg      <= 1'b0;
            periph_n_reg   <= 1'b0;
            ready_reg      <= 1'b0;
        end else if (!extn_s) begin
            // Button press overrides every other event.
            state_reg      <= RST_HOLD;
            stable_cnt_reg <= '0;
            stag_cnt_reg   <= '0;
            loss_cnt_reg   <= '0;
            hold_cnt_reg   <= '0;
            fab_n_reg      <= 1'b0;
            periph_n_reg   <= 1'b0;
            ready_reg      <= 1'b0;
        end else begin
            case (state_reg)
                RST_HOLD: begin
                    state_reg <= WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    stable_cnt_reg <= '0;
                    if (lock_s) state_reg <= STABLE;
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_reg      <= WAIT_LOCK;
                        stable_cnt_reg <= '0;
                    end else if (stable_cnt_reg == STABLE_LAST) begin
                        state_reg    <= CORE_UP;
                        fab_n_reg    <= 1'b1;
                        stag_cnt_reg <= '0;
                        loss_cnt_reg <= '0;
                    end else begin
                        stable_cnt_reg <= stable_cnt_reg + 1'b1;
                    end
                end
                CORE_UP, RUN: begin
                    if (!lock_s && loss_cnt_reg == LOSS_LAST) begin
                        state_reg    <= WAIT_LOCK;
                        fab_n_reg    <= 1'b0;
                        periph_n_reg <= 1'b0;
                        ready_reg    <= 1'b0;
                        loss_cnt_reg <= '0;
                        if (loss_total_reg != '1) loss_total_reg <= loss_total_reg + 1'b1;
                    end else begin
                        loss_cnt_reg <= lock_s ? '0 : loss_cnt_reg + 1'b1;
                        if (SW_RST_REQ) begin
                            state_reg    <= SW_HOLD;
                            fab_n_reg    <= 1'b0;
                            periph_n_reg <= 1'b0;
                            ready_reg    <= 1'b0;
                            hold_cnt_reg <= '0;
                            loss_cnt_reg <= '0;
                        end else if (state_reg == CORE_UP) begin
                            if (stag_cnt_reg == STAG_LAST) begin
                                state_reg    <= RUN;
                                periph_n_reg <= 1'b1;
                                ready_reg    <= 1'b1;
                            end else begin
                                stag_cnt_reg <= stag_cnt_reg + 1'b1;
                            end
                        end
                    end
                end
                SW_HOLD: begin
                    if (hold_cnt_reg == HOLD_LAST) begin
                        state_reg    <= WAIT_LOCK;
                        hold_cnt_reg <= '0;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg    <= RST_HOLD;
                    fab_n_reg    <= 1'b0;
                    periph_n_reg <= 1'b0;
                    ready_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign FAB_RESET_N    = fab_n_reg;
    assign PERIPH_RESET_N = periph_n_reg;
    assign READY          = ready_reg;
    assign STATE          = state_reg;
    assign LOCK_LOSS_CNT  = loss_total_reg;

endmodule

// File: tb/tb_fabosc_rst_seq.sv
// Directed bench for fabosc_rst_seq with small parameter values.
module tb_fabosc_rst_seq;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       PLL_LOCK;
    logic       EXT_RST_N;
    logic       SW_RST_REQ;
    logic       FAB_RESET_N;
    logic       PERIPH_RESET_N;
    logic       READY;
    logic [2:0] STATE;
    logic [7:0] LOCK_LOSS_CNT;

    int tests_run    = 0;
    int tests_failed = 0;

    fabosc_rst_seq #(
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (16),
        .STAGGER_CYCLES     (4),
        .LOSS_FILTER        (3),
        .SW_HOLD_CYCLES     (8)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .PLL_LOCK       (PLL_LOCK),
        .EXT_RST_N      (EXT_RST_N),
        .SW_RST_REQ     (SW_RST_REQ),
        .FAB_RESET_N    (FAB_RESET_N),
        .PERIPH_RESET_N (PERIPH_RESET_N),
        .READY          (READY),
        .STATE          (STATE),
        .LOCK_LOSS_CNT  (LOCK_LOSS_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Reset for 5 edges, release, raise PLL_LOCK after relative edge 10.
    task automatic power_up();
        RESET = 1'b1; PLL_LOCK = 1'b0; EXT_RST_N = 1'b1; SW_RST_REQ = 1'b0;
        tick(5);
        RESET = 1'b0;
        tick(5);
        PLL_LOCK = 1'b1;
    endtask

    task automatic test_reset();
        tick(2);
        tests_run++; if (FAB_RESET_N !== 1'b0) begin tests_failed++; $display("FAIL reset_fab: got %b expected 0", FAB_RESET_N); end
        tests_run++; if (PERIPH_RESET_N !== 1'b0) begin tests_failed++; $display("FAIL reset_periph: got %b expected 0", PERIPH_RESET_N); end
        tests_run++; if (READY !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b expected 0", READY); end
        tests_run++; if (STATE !== 3'd0) begin tests_failed++; $display("FAIL reset_state: got %0d expected 0", STATE); end
        tests_run++; if (LOCK_LOSS_CNT !== 8'd0) begin tests_failed++; $display("FAIL reset_llc: got %0d expected 0", LOCK_LOSS_CNT); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_power_up();
        power_up();
        tick(18); // edge 28
        tests_run++; if (FAB_RESET_N !== 1'b0) begin tests_failed++; $display("FAIL pu_fab_28: got %b expected 0", FAB_RESET_N); end
        tests_run++; if (STATE !== 3'd2) begin tests_failed++; $display("FAIL pu_state_28: got %0d expected 2", STATE); end
        tick(1); // edge 29
        tests_run++; if (FAB_RESET_N !== 1'b1) begin tests_failed++; $display("FAIL pu_fab_29: got %b expected 1", FAB_RESET_N); end
        tests_run++; if (STATE !== 3'd3) begin tests_failed++; $display("FAIL pu_state_29: got %0d expected 3", STATE); end
        tick(3); // edge 32
        tests_run++; if (PERIPH_RESET_N !== 1'b0) begin tests_failed++; $display("FAIL pu_periph_32: got %b expected 0", PERIPH_RESET_N); end
        tick(1); // edge 33
        tests_run++; if (PERIPH_RESET_N !== 1'b1) begin tests_failed++; $display("FAIL pu_periph_33: got %b expected 1", PERIPH_RESET_N); end
        tests_run++; if (READY !== 1'b1) begin tests_failed++; $display("FAIL pu_ready_33: got %b expected 1", READY); end
        tests_run++; if (STATE !== 3'd4) begin tests_failed++; $display("FAIL pu_state_33: got %0d expected 4", STATE); end
        $display("[TB] test_power_up done");
    endtask

    task automatic test_glitch_filter();
        PLL_LOCK = 1'b0; tick(2); PLL_LOCK = 1'b1; tick(4);
        tests_run++; if (FAB_RESET_N !== 1'b1 || PERIPH_RESET_N !== 1'b1) begin tests_failed++; $display("FAIL glitch2_resets: got %b%b expected 11", FAB_RESET_N, PERIPH_RESET_N); end
        tests_run++; if (STATE !== 3'd4) begin tests_failed++; $display("FAIL glitch2_state: got %0d expected 4", STATE); end
        PLL_LOCK = 1'b0; tick(4);
        tests_run++; if (STATE !== 3'd4) begin tests_failed++; $display("FAIL glitch3_pre_state: got %0d expected 4", STATE); end
        tick(1);
        tests_run++; if (FAB_RESET_N !== 1'b0 || PERIPH_RESET_N !== 1'b0) begin tests_failed++; $display("FAIL glitch3_resets: got %b%b expected 00", FAB_RESET_N, PERIPH_RESET_N); end
        tests_run++; if (STATE !== 3'd1) begin tests_failed++; $display("FAIL glitch3_state: got %0d expected 1", STATE); end
        tests_run++; if (LOCK_LOSS_CNT !== 8'd1) begin tests_failed++; $display("FAIL glitch3_llc: got %0d expected 1", LOCK_LOSS_CNT); end
        PLL_LOCK = 1'b1;
        $display("[TB] test_glitch_filter done");
    endtask

    task automatic test_unstable_lock();
        power_up();
        tick(10); // edge 20
        PLL_LOCK = 1'b0; tick(1); PLL_LOCK = 1'b1;
        tick(1); // edge 22
        tests_run++; if (STATE !== 3'd2) begin tests_failed++; $display("FAIL unst_state_22: got %0d expected 2", STATE); end
        tick(1); // edge 23
        tests_run++; if (STATE !== 3'd1) begin tests_failed++; $display("FAIL unst_state_23: got %0d expected 1", STATE); end
        tick(1); // edge 24
        tests_run++; if (STATE !== 3'd2) begin tests_failed++; $display("FAIL unst_state_24: got %0d expected 2", STATE); end
        tick(15); // edge 39
        tests_run++; if (FAB_RESET_N !== 1'b0) begin tests_failed++; $display("FAIL unst_fab_39: got %b expected 0", FAB_RESET_N); end
        tick(1); // edge 40
        tests_run++; if (FAB_RESET_N !== 1'b1) begin tests_failed++; $display("FAIL unst_fab_40: got %b expected 1", FAB_RESET_N); end
        tests_run++; if (LOCK_LOSS_CNT !== 8'd0) begin tests_failed++; $display("FAIL unst_llc: got %0d expected 0", LOCK_LOSS_CNT); end
        $display("[TB] test_unstable_lock done");
    endtask

    task automatic test_sw_reset();
        power_up();
        tick(23); // edge 33, RUN
        tests_run++; if (STATE !== 3'd4) begin tests_failed++; $display("FAIL sw_pre_state: got %0d expected 4", STATE); end
        SW_RST_REQ = 1'b1; tick(1); SW_RST_REQ = 1'b0;
        tests_run++; if (STATE !== 3'd5) begin tests_failed++; $display("FAIL sw_state_enter: got %0d expected 5", STATE); end
        tests_run++; if (FAB_RESET_N !== 1'b0 || PERIPH_RESET_N !== 1'b0) begin tests_failed++; $display("FAIL sw_resets: got %b%b expected 00", FAB_RESET_N, PERIPH_RESET_N); end
        tick(7);
        tests_run++; if (STATE !== 3'd5) begin tests_failed++; $display("FAIL sw_state_hold7: got %0d expected 5", STATE); end
        tick(1);
        tests_run++; if (STATE !== 3'd1) begin tests_failed++; $display("FAIL sw_state_exit: got %0d expected 1", STATE); end
        tick(16);
        tests_run++; if (FAB_RESET_N !== 1'b0 || STATE !== 3'd2) begin tests_failed++; $display("FAIL sw_requal_pre: got fab=%b state=%0d expected fab=0 state=2", FAB_RESET_N, STATE); end
        tick(1);
        tests_run++; if (FAB_RESET_N !== 1'b1 || STATE !== 3'd3) begin tests_failed++; $display("FAIL sw_requal_up: got fab=%b state=%0d expected fab=1 state=3", FAB_RESET_N, STATE); end
        $display("[TB] test_sw_reset done");
    endtask

    task automatic test_simultaneous();
        tick(4);
        tests_run++; if (STATE !== 3'd4) begin tests_failed++; $display("FAIL sim_pre_state: got %0d expected 4", STATE); end
        PLL_LOCK = 1'b0; tick(2);
        EXT_RST_N = 1'b0; tick(2);
        tests_run++; if (STATE !== 3'd4) begin tests_failed++; $display("FAIL sim_mid_state: got %0d expected 4", STATE); end
        SW_RST_REQ = 1'b1; tick(1); SW_RST_REQ = 1'b0;
        tests_run++; if (STATE !== 3'd0) begin tests_failed++; $display("FAIL sim_state: got %0d expected 0", STATE); end
        tests_run++; if (LOCK_LOSS_CNT !== 8'd0) begin tests_failed++; $display("FAIL sim_llc: got %0d expected 0", LOCK_LOSS_CNT); end
        tests_run++; if (FAB_RESET_N !== 1'b0) begin tests_failed++; $display("FAIL sim_fab: got %b expected 0", FAB_RESET_N); end
        EXT_RST_N = 1'b1; PLL_LOCK = 1'b1;
        $display("[TB] test_simultaneous done");
    endtask

    task automatic test_saturation();
        power_up();
        tick(23); // RUN
        for (int i = 0; i < 260; i++) begin
            PLL_LOCK = 1'b0; tick(5);
            if (i == 99) begin
                tests_run++; if (LOCK_LOSS_CNT !== 8'd100) begin tests_failed++; $display("FAIL sat_llc_100: got %0d expected 100", LOCK_LOSS_CNT); end
            end
            PLL_LOCK = 1'b1; tick(25);
        end
        tests_run++; if (LOCK_LOSS_CNT !== 8'd255) begin tests_failed++; $display("FAIL sat_llc_255: got %0d expected 255", LOCK_LOSS_CNT); end
        tests_run++; if (STATE !== 3'd4) begin tests_failed++; $display("FAIL sat_state: got %0d expected 4", STATE); end
        $display("[TB] test_saturation done");
    endtask

    task automatic test_reset_mid_op();
        PLL_LOCK = 1'b0; tick(5); PLL_LOCK = 1'b1;
        tick(19); // CORE_UP
        tests_run++; if (STATE !== 3'd3 || FAB_RESET_N !== 1'b1) begin tests_failed++; $display("FAIL mid_pre: got state=%0d fab=%b expected state=3 fab=1", STATE, FAB_RESET_N); end
        tests_run++; if (LOCK_LOSS_CNT !== 8'd255) begin tests_failed++; $display("FAIL mid_pre_llc: got %0d expected 255", LOCK_LOSS_CNT); end
        RESET = 1'b1; #1;
        tests_run++; if (FAB_RESET_N !== 1'b0 || PERIPH_RESET_N !== 1'b0 || READY !== 1'b0) begin tests_failed++; $display("FAIL mid_async_outs: got %b%b%b expected 000", FAB_RESET_N, PERIPH_RESET_N, READY); end
        tests_run++; if (STATE !== 3'd0) begin tests_failed++; $display("FAIL mid_async_state: got %0d expected 0", STATE); end
        tests_run++; if (LOCK_LOSS_CNT !== 8'd0) begin tests_failed++; $display("FAIL mid_async_llc: got %0d expected 0", LOCK_LOSS_CNT); end
        $display("[TB] test_reset_mid_op done");
    endtask

    initial begin
        RESET = 1'b1; PLL_LOCK = 1'b0; EXT_RST_N = 1'b1; SW_RST_REQ = 1'b0;
        test_reset();
        test_power_up();
        test_glitch_filter();
        test_unstable_lock();
        test_sw_reset();
        test_simultaneous();
        test_saturation();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
